ahb_req_arbiter: RTL and testbench

//  Round-robin scheduler sharing one simple AHB master port between N_REQ requesters.

---
 rtl/ahb_req_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ahb_req_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_req_arbiter.sv
// rtl/ahb_req_arbiter.sv - round-robin arbiter sharing one AHB master port between N_REQ requesters
// Optional XFER watchdog enabled by defining ARB_TIMEOUT_EN.
module ahb_req_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_wr,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic [N_REQ-1:0]           err,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_write,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [N_REQ-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_q, wr_d;
  logic                valid_q, valid_d;

  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    cand;
  logic                timeout_hit;

  if (TIMEOUT < 1) begin : g_timeout_range_invalid
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Scan starts just after the last grantee, so it ends up with lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % N_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          idx_d          = sel_idx;
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          addr_d         = req_addr[sel_idx*ADDR_W +: ADDR_W];
          data_d         = req_data[sel_idx*DATA_W +: DATA_W];
          wr_d           = req_wr[sel_idx];
          valid_d        = 1'b1;
          state_d        = S_XFER;
`ifdef ARB_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end
      end
      S_XFER: begin
        // m_ready beats the watchdog when both land in the same cycle.
        if (m_ready) begin
          done_d[idx_q] = 1'b1;
          rr_d          = idx_q;
          valid_d       = 1'b0;
          gnt_d         = '0;
          state_d       = S_DONE;
        end else if (timeout_hit) begin
          err_d[idx_q]  = 1'b1;
          rr_d          = idx_q;
          valid_d       = 1'b0;
          gnt_d         = '0;
          state_d       = S_DONE;
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d         = cnt_q + 1'b1;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      rr_q    <= IDX_W'(N_REQ - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign m_addr  = addr_q;
  assign m_data  = data_q;
  assign m_write = wr_q;
  assign m_valid = valid_q;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// tb/tb_ahb_req_arbiter.sv - self-checking bench for ahb_req_arbiter (vector table, corner sequences, random vs model)
module tb_ahb_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 15;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [N-1:0]      req, req_wr;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      gnt, done, err;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_data;
  logic              m_write, m_valid, m_ready;

  ahb_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .done(done),
    .err(err), .m_addr(m_addr), .m_data(m_data), .m_write(m_write),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the port, who went last, how long it has waited.
  int          owner;
  int          last;
  int          waited;
  bit          finishing;
  logic [N-1:0]  e_gnt, e_done, e_err;
  logic          e_valid, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    owner = -1; last = N - 1; waited = 0; finishing = 0;
    e_gnt = '0; e_done = '0; e_err = '0; e_valid = 0; e_wr = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic finish_xfer(input bit ok);
    e_done = '0; e_err = '0;
    if (ok) e_done[owner] = 1'b1; else e_err[owner] = 1'b1;
    last = owner; owner = -1; e_gnt = '0; e_valid = 0; finishing = 1;
  endtask

  task automatic model_edge();
    bit found;
    if (finishing) begin
      finishing = 0; e_done = '0; e_err = '0;
    end else if (owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last + k) % N;
        if (!found && req[c]) begin
          found = 1; owner = c; waited = 0;
          e_gnt = '0; e_gnt[c] = 1'b1; e_valid = 1;
          e_addr = req_addr[c*AW +: AW]; e_data = req_data[c*DW +: DW]; e_wr = req_wr[c];
        end
      end
    end else if (m_ready) begin
      finish_xfer(1);
`ifdef ARB_TIMEOUT_EN
    end else if (waited + 1 == TO) begin
      finish_xfer(0);
`endif
    end else begin
      waited++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gnt"},     64'(gnt),     64'(e_gnt));
    check({tag, ".done"},    64'(done),    64'(e_done));
    check({tag, ".err"},     64'(err),     64'(e_err));
    check({tag, ".m_valid"}, 64'(m_valid), 64'(e_valid));
    if (e_valid) begin
      check({tag, ".m_addr"},  64'(m_addr),  64'(e_addr));
      check({tag, ".m_data"},  64'(m_data),  64'(e_data));
      check({tag, ".m_write"}, 64'(m_write), 64'(e_wr));
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge HCLK);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0; req = '0; m_ready = 1'b0;
    #1;
    check("rst.gnt", 64'(gnt), 64'h0);
    check("rst.done", 64'(done), 64'h0);
    check("rst.err", 64'(err), 64'h0);
    check("rst.m_valid", 64'(m_valid), 64'h0);
    check("rst.m_write", 64'(m_write), 64'h0);
    check("rst.m_addr", 64'(m_addr), 64'h0);
    check("rst.m_data", 64'(m_data), 64'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] v_req;
    logic         v_rdy;
    logic [N-1:0] x_gnt;
    logic [N-1:0] x_done;
    logic         x_valid;
  } vec_t;

  vec_t tbl[$];

  initial begin
    HRESETn = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_data = '0; m_ready = 1'b0;
    model_reset();

    // Single transfer then round robin from reset with req=11 held.
    tbl.push_back('{1, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1});
    tbl.push_back('{0, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1});
    tbl.push_back('{0, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0});
    tbl.push_back('{0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{1, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1});
    tbl.push_back('{0, 2'b11, 1'b1, 2'b00, 2'b01, 1'b0});
    tbl.push_back('{0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1});
    tbl.push_back('{0, 2'b11, 1'b1, 2'b00, 2'b10, 1'b0});
    tbl.push_back('{0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1});
    tbl.push_back('{0, 2'b11, 1'b1, 2'b00, 2'b01, 1'b0});
    tbl.push_back('{0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1});

    req_addr = {4'h5, 4'hA};
    req_data = {32'h12345678, 32'hDEADBEEF};
    req_wr   = 2'b01;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      req = tbl[i].v_req; m_ready = tbl[i].v_rdy;
      @(posedge HCLK);
      #1;
      check($sformatf("vec%0d.gnt", i), 64'(gnt), 64'(tbl[i].x_gnt));
      check($sformatf("vec%0d.done", i), 64'(done), 64'(tbl[i].x_done));
      check($sformatf("vec%0d.m_valid", i), 64'(m_valid), 64'(tbl[i].x_valid));
      if (tbl[i].x_gnt == 2'b01) begin
        check($sformatf("vec%0d.m_addr", i), 64'(m_addr), 64'hA);
        check($sformatf("vec%0d.m_data", i), 64'(m_data), 64'hDEADBEEF);
        check($sformatf("vec%0d.m_write", i), 64'(m_write), 64'h1);
      end else if (tbl[i].x_gnt == 2'b10) begin
        check($sformatf("vec%0d.m_addr", i), 64'(m_addr), 64'h5);
        check($sformatf("vec%0d.m_data", i), 64'(m_data), 64'h12345678);
        check($sformatf("vec%0d.m_write", i), 64'(m_write), 64'h0);
      end
    end

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    req = 2'b01; m_ready = 1'b0;
    tick("arst_pre");
    #2 HRESETn = 1'b0;
    #1;
    check("arst.gnt", 64'(gnt), 64'h0);
    check("arst.m_valid", 64'(m_valid), 64'h0);
    check("arst.done", 64'(done), 64'h0);
    model_reset();
    req = '0;
    @(posedge HCLK);
    #1;
    check("arst.done_after_edge", 64'(done), 64'h0);
    HRESETn = 1'b1;

    // Captured address survives requester changes during XFER.
    req_addr = {4'h5, 4'hA};
    req = 2'b01; m_ready = 1'b0;
    tick("stab_grant");
    req_addr[3:0] = 4'h3; req = 2'b00;
    tick("stab_w1");
    check("stab.m_addr", 64'(m_addr), 64'hA);
    m_ready = 1'b1;
    tick("stab_done");
    m_ready = 1'b0;
    tick("stab_idle");

`ifdef ARB_TIMEOUT_EN
    do_reset();
    req = 2'b01; m_ready = 1'b0;
    tick("to_grant");
    for (int c = 1; c < TO; c++) tick("to_wait");
    tick("to_fire");
    check("to.err", 64'(err), 64'h1);
    check("to.done", 64'(done), 64'h0);
    req = 2'b10;
    tick("to_after");
    tick("to_next_grant");
    check("to.next_gnt", 64'(gnt), 64'h2);
    m_ready = 1'b1;
    tick("to_next_done");
    req = 2'b00; m_ready = 1'b0;
    tick("to_idle");

    do_reset();
    req = 2'b01; m_ready = 1'b0;
    tick("tie_grant");
    for (int c = 1; c < TO; c++) tick("tie_wait");
    m_ready = 1'b1;
    tick("tie_fire");
    check("tie.done", 64'(done), 64'h1);
    check("tie.err", 64'(err), 64'h0);
`else
    do_reset();
    req = 2'b01; m_ready = 1'b0;
    tick("wait_grant");
    for (int c = 0; c < 3 * TO; c++) tick("wait_long");
    check("wait.gnt_held", 64'(gnt), 64'h1);
    m_ready = 1'b1;
    tick("wait_done");
    check("wait.done", 64'(done), 64'h1);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      req      = N'($urandom);
      req_wr   = N'($urandom);
      req_addr = (N*AW)'($urandom);
      req_data = {$urandom, $urandom};
      m_ready  = (($urandom % 8) < 3);
      if (($urandom % 64) == 0) m_ready = 1'b0;
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
